rect_click_detect: RTL and testbench

- Upstream stage feeding the game state machine's rect_clicked_play input.
- Detects a complete mouse click (press and release) inside the clickable rectangle currently published by the state machine (hstart/vstart/hlength/vlength).
- Debounces the mouse button and provides hover, press-armed, one-cycle click pulse and sticky clicked outputs.
- All logic is in the pclk domain.

---
 rtl/rect_click_detect_if.sv | 28 ++
 rtl/rect_click_detect.sv | 153 +++++++++++++++
 tb/tb_rect_click_detect.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_click_detect_if.sv
// Pointer, rectangle geometry and click-status signals shared between
// the click detector and whatever drives the pointer and the rectangle.
interface rect_click_detect_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [10:0] hstart;
    logic [10:0] vstart;
    logic [10:0] hlength;
    logic [10:0] vlength;
    logic        clr;
    logic        rect_hover;
    logic        press_active;
    logic        click_pulse;
    logic        rect_clicked;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left,
        output hstart, vstart, hlength, vlength, clr,
        input  rect_hover, press_active, click_pulse, rect_clicked
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left,
        input  hstart, vstart, hlength, vlength, clr,
        output rect_hover, press_active, click_pulse, rect_clicked
    );
endinterface

// File: rtl/rect_click_detect.sv
// Detects a debounced press-and-release of the left mouse button entirely
// inside the published rectangle; provides hover, armed, pulse and sticky flag.
module rect_click_detect #(
    parameter int DEBOUNCE = 4
) (
    input  logic                pclk,
    input  logic                rst_d,
    rect_click_detect_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        BLOCKED = 2'd2,
        FIRE    = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE - 1);

    logic [11:0] h_lo_s;
    logic [11:0] v_lo_s;
    logic [11:0] h_hi_s;
    logic [11:0] v_hi_s;
    logic        inside_s;

    logic        sync1_r;
    logic        sync2_r;
    logic        btn_db_r;
    logic        btn_db_q_r;
    logic [15:0] db_cnt_r;
    logic        rise_s;
    logic        fall_s;

    logic        hover_r;
    logic        press_r;
    logic        pulse_r;
    logic        clicked_r;

    state_t      state_r;
    state_t      state_next_s;

    // Pointer-in-rectangle test; 12-bit sums cannot overflow for 11-bit operands
    always_comb begin
        h_lo_s   = {1'b0, bus.hstart};
        v_lo_s   = {1'b0, bus.vstart};
        h_hi_s   = {1'b0, bus.hstart} + {1'b0, bus.hlength};
        v_hi_s   = {1'b0, bus.vstart} + {1'b0, bus.vlength};
        inside_s = (bus.hlength != 11'd0) && (bus.vlength != 11'd0) &&
                   (bus.mouse_xpos >= h_lo_s) && (bus.mouse_xpos < h_hi_s) &&
                   (bus.mouse_ypos >= v_lo_s) && (bus.mouse_ypos < v_hi_s);
    end

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge pclk) begin
        if (rst_d) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= bus.mouse_left;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: button flips only after DEBOUNCE consecutive differing samples
    always_ff @(posedge pclk) begin
        if (rst_d) begin
            btn_db_r   <= 1'b0;
            btn_db_q_r <= 1'b0;
            db_cnt_r   <= 16'd0;
        end else begin
            btn_db_q_r <= btn_db_r;
            if (sync2_r == btn_db_r) begin
                db_cnt_r <= 16'd0;
            end else if (db_cnt_r == DB_LAST) begin
                btn_db_r <= ~btn_db_r;
                db_cnt_r <= 16'd0;
            end else begin
                db_cnt_r <= db_cnt_r + 16'd1;
            end
        end
    end

    assign rise_s = btn_db_r & ~btn_db_q_r;
    assign fall_s = ~btn_db_r & btn_db_q_r;

    // State register and registered hover
    always_ff @(posedge pclk) begin
        if (rst_d) begin
            state_r <= IDLE;
            hover_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            hover_r <= inside_s;
        end
    end

    // Next-state logic; leaving the rectangle while armed beats a release
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_next_s = hover_r ? ARMED : BLOCKED;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMED: begin
                if (!hover_r) begin
                    state_next_s = BLOCKED;
                end else if (fall_s) begin
                    state_next_s = FIRE;
                end else begin
                    state_next_s = ARMED;
                end
            end
            BLOCKED: begin
                if (fall_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BLOCKED;
                end
            end
            FIRE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // press_active follows ARMED entry; pulse and sticky flag decode FIRE
    always_ff @(posedge pclk) begin
        if (rst_d) begin
            press_r   <= 1'b0;
            pulse_r   <= 1'b0;
            clicked_r <= 1'b0;
        end else begin
            press_r <= (state_next_s == ARMED);
            pulse_r <= (state_r == FIRE);
            if (state_r == FIRE) begin
                clicked_r <= 1'b1;
            end else if (bus.clr) begin
                clicked_r <= 1'b0;
            end else begin
                clicked_r <= clicked_r;
            end
        end
    end

    assign bus.rect_hover   = hover_r;
    assign bus.press_active = press_r;
    assign bus.click_pulse  = pulse_r;
    assign bus.rect_clicked = clicked_r;

endmodule

// File: tb/tb_rect_click_detect.sv
// Directed bench for rect_click_detect with DEBOUNCE = 4 and hand-derived
// cycle-exact expectations.
module tb_rect_click_detect;

    logic pclk;
    logic rst_d;
    int   vectors;
    int   miscompares;

    rect_click_detect_if rif ();

    rect_click_detect #(.DEBOUNCE(4)) dut (
        .pclk  (pclk),
        .rst_d (rst_d),
        .bus   (rif)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pos(input int x, input int y);
        rif.mouse_xpos = 12'(x);
        rif.mouse_ypos = 12'(y);
    endtask

    task automatic hover_at(input string tag, input int x, input int y, input int exp);
        set_pos(x, y);
        cyc(1);
        check(tag, int'(rif.rect_hover), exp);
    endtask

    // Runs n cycles, reporting how many pulses appeared and the first edge index
    task automatic count_pulses(input int n, output int cnt, output int first);
        cnt   = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            cyc(1);
            if (rif.click_pulse) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hover"},   int'(rif.rect_hover),   0);
        check({tag, "_press"},   int'(rif.press_active), 0);
        check({tag, "_pulse"},   int'(rif.click_pulse),  0);
        check({tag, "_clicked"}, int'(rif.rect_clicked), 0);
    endtask

    initial begin
        int n;
        int first;
        int act;
        vectors     = 0;
        miscompares = 0;

        rst_d          = 1'b1;
        rif.mouse_left = 1'b1;
        rif.clr        = 1'b0;
        rif.hstart     = 11'd380;
        rif.vstart     = 11'd186;
        rif.hlength    = 11'd300;
        rif.vlength    = 11'd100;
        set_pos(400, 200);

        // Reset with button held and pointer inside
        cyc(3);
        check_all_zero("reset");
        rst_d = 1'b0;
        cyc(1);
        check("post_reset_hover", int'(rif.rect_hover), 1);
        set_pos(100, 100);
        cyc(7);
        check("held_after_reset_blocked", int'(rif.press_active), 0);
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("reset_release_no_pulse", n, 0);
        check("reset_release_no_flag", int'(rif.rect_clicked), 0);

        // Valid click inside
        set_pos(400, 200);
        cyc(2);
        rif.mouse_left = 1'b1;
        cyc(6);
        check("armed_edge6", int'(rif.press_active), 0);
        cyc(1);
        check("armed_edge7", int'(rif.press_active), 1);
        cyc(13);
        rif.mouse_left = 1'b0;
        cyc(7);
        check("click_edge7", int'(rif.click_pulse), 0);
        cyc(1);
        check("click_edge8", int'(rif.click_pulse), 1);
        check("clicked_set", int'(rif.rect_clicked), 1);
        cyc(1);
        check("click_one_cycle", int'(rif.click_pulse), 0);
        cyc(10);
        check("clicked_held", int'(rif.rect_clicked), 1);
        check("press_released", int'(rif.press_active), 0);

        // clr on its own
        rif.clr = 1'b1;
        cyc(1);
        rif.clr = 1'b0;
        check("clr_alone", int'(rif.rect_clicked), 0);

        // Rectangle boundaries
        hover_at("x679", 679, 200, 1);
        hover_at("x680", 680, 200, 0);
        hover_at("x379", 379, 200, 0);
        hover_at("x380", 380, 200, 1);
        hover_at("y285", 400, 285, 1);
        hover_at("y286", 400, 286, 0);
        hover_at("y185", 400, 185, 0);

        // Zero width disables the rectangle
        rif.hlength = 11'd0;
        hover_at("hlen0_hover", 400, 200, 0);
        rif.mouse_left = 1'b1;
        cyc(20);
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("hlen0_no_pulse", n, 0);
        rif.hlength = 11'd300;

        // Press outside, release inside
        set_pos(100, 100);
        cyc(2);
        rif.mouse_left = 1'b1;
        cyc(10);
        set_pos(400, 200);
        cyc(10);
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("outside_press_no_pulse", n, 0);

        // Drag out and back in
        cyc(2);
        rif.mouse_left = 1'b1;
        cyc(10);
        check("drag_armed", int'(rif.press_active), 1);
        set_pos(100, 100);
        cyc(1);
        check("drag_hover_drop", int'(rif.rect_hover), 0);
        check("drag_press_still", int'(rif.press_active), 1);
        cyc(1);
        check("drag_press_drop", int'(rif.press_active), 0);
        set_pos(400, 200);
        cyc(5);
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("drag_no_pulse", n, 0);
        check("drag_no_flag", int'(rif.rect_clicked), 0);

        // Length collapses while armed
        rif.mouse_left = 1'b1;
        cyc(8);
        check("geom_armed", int'(rif.press_active), 1);
        rif.hlength = 11'd0;
        cyc(2);
        check("geom_blocked", int'(rif.press_active), 0);
        rif.hlength = 11'd300;
        cyc(3);
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("geom_no_pulse", n, 0);

        // Three-cycle glitch is filtered out
        rif.mouse_left = 1'b1;
        cyc(3);
        rif.mouse_left = 1'b0;
        act = 0;
        n   = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (rif.press_active) act++;
            if (rif.click_pulse) n++;
        end
        check("glitch_no_arm", act, 0);
        check("glitch_no_pulse", n, 0);

        // Bouncy press then steady hold: exactly one click
        rif.mouse_left = 1'b1; cyc(2);
        rif.mouse_left = 1'b0; cyc(2);
        rif.mouse_left = 1'b1; cyc(2);
        rif.mouse_left = 1'b0; cyc(2);
        rif.mouse_left = 1'b1;
        cyc(20);
        check("bounce_armed", int'(rif.press_active), 1);
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("bounce_one_pulse", n, 1);
        check("bounce_pulse_edge", first, 8);
        check("bounce_flag", int'(rif.rect_clicked), 1);

        // clr coincident with FIRE: set wins
        rif.clr = 1'b1;
        cyc(1);
        rif.clr = 1'b0;
        check("clr_before_fire", int'(rif.rect_clicked), 0);
        rif.mouse_left = 1'b1;
        cyc(20);
        rif.mouse_left = 1'b0;
        cyc(7);
        rif.clr = 1'b1;
        cyc(1);
        rif.clr = 1'b0;
        check("fire_clr_pulse", int'(rif.click_pulse), 1);
        check("fire_clr_set_wins", int'(rif.rect_clicked), 1);
        cyc(1);
        check("fire_clr_held", int'(rif.rect_clicked), 1);

        // Reset while armed
        cyc(5);
        rif.mouse_left = 1'b1;
        cyc(8);
        check("rst_armed_pre", int'(rif.press_active), 1);
        rst_d = 1'b1;
        cyc(1);
        check_all_zero("rst_armed");
        rst_d = 1'b0;
        rif.mouse_left = 1'b0;
        count_pulses(20, n, first);
        check("rst_armed_no_pulse", n, 0);
        check("rst_armed_idle", int'(rif.press_active), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
